alu_mc: RTL
===========

# alu_mc

Multi-cycle, parametrised successor to the single-cycle ALU. It widens the datapath to WIDTH bits and adds OR, an iterative unsigned multiply and arithmetic right shift. Operand and result transfers use valid/ready handshakes, and each result carries a registered flag set. It sits between the decode/issue stage and writeback, and holds one operation at a time.

## Interface
- WIDTH, 32: operand/result width; must be at least 8 and a power of two.
- MUL_EN, 1: 1 enables the iterative multiplier; 0 makes opcode MUL return a zero result.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset; asserts immediately, releases synchronously to clk.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept an operation.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B; for shifts only b[$clog2(WIDTH)-1:0] is used.
- opcode  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 MUL, 101 SLL, 110 SRL, 111 SRA.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  registered result.
- carry, zero, negative, overflow  out  1 each  registered flags.

## Operation
- An operation is accepted when in_valid && in_ready. a, b and opcode are captured on that edge.
- FSM states: IDLE, MUL, DONE.
  - IDLE: in_ready=1. On accept of MUL with MUL_EN=1, go to MUL; on any other accept, compute, register and go to DONE.
  - MUL: shift-add, one multiplier bit per cycle, exactly WIDTH cycles, then go to DONE.
  - DONE: out_valid=1. Result and flags are held stable until out_ready, then go to IDLE.
- in_ready is high only in IDLE. Accept and output never overlap.
- All arithmetic is modulo 2^WIDTH.
- ADD:
  - carry = carry-out of bit WIDTH-1.
  - overflow = operands have the same sign and the result sign differs.
- SUB:
  - carry = borrow, i.e. unsigned b > a.
  - overflow = operands have different signs and the result sign differs from a.
- AND, OR: carry=0, overflow=0.
- MUL:
  - result = low WIDTH bits of the unsigned product.
  - carry = overflow = (high WIDTH bits != 0).
  - With MUL_EN=0: result=0, carry=0, overflow=0, latency as for single-cycle ops.
- SLL, SRL, SRA (shift amount s):
  - carry = last bit shifted out (a[WIDTH-s] for SLL, a[s-1] for SRL/SRA); overflow=0.
  - s=0 gives result=a and carry=0.
  - SRA replicates a[WIDTH-1].
- For every opcode: zero = (result==0), negative = result[WIDTH-1].

## Timing
- Reset values: in_ready=0 while rst_n=0 and 1 from the first cycle after release; out_valid=0; result=0; all four flags 0; state=IDLE.
- Single-cycle ops: out_valid rises on the edge after accept (latency 1).
- MUL with MUL_EN=1: out_valid rises WIDTH+1 edges after accept (33 for WIDTH=32).
- Throughput:
  - Single-cycle ops with out_ready held high: one op per 2 cycles.
  - MUL: one per WIDTH+2 cycles.
- in_valid while in_ready=0 is ignored. The producer must hold its beat until accepted.
- out_ready while out_valid=0 has no effect.
- Reset mid-MUL or mid-DONE aborts the operation: the partial product is discarded and no out_valid is produced for it.
- a, b and opcode changing after accept have no effect on the operation in flight.

## Structure
- Package alu_pkg:
  - opcode enum alu_op_e (ALU_ADD..ALU_SRA).
  - state enum alu_state_e.
  - flag struct alu_flags_t {carry, zero, negative, overflow}.
- Sub-module alu_mul_iter:
  - Signals: start, a, b, busy, done, prod_lo, prod_hi.
  - Contains the WIDTH-cycle shift-add datapath and its bit counter.
  - Instantiated only when MUL_EN=1 (generate).
- Top level: FSM, single-cycle combinational datapath, and output/flag registers.

## Test plan
- ADD a=32'h7FFF_FFFF, b=1 -> result 32'h8000_0000; overflow=1, negative=1, carry=0, zero=0; out_valid exactly 1 cycle after accept.
- SUB a=3, b=5 -> result 32'hFFFF_FFFE; carry=1, negative=1, overflow=0. SUB a=5, b=5 -> result 0, zero=1, carry=0.
- MUL a=32'h0001_0000, b=32'h0001_0000 -> result 0; zero=1, carry=1, overflow=1; out_valid exactly 33 cycles after accept; in_ready=0 throughout. MUL 7*6 -> result 42, carry=0.
- SRA a=32'h8000_0000, b=4 -> result 32'hF800_0000, carry=0. SLL a=32'h8000_0001, b=1 -> result 2, carry=1. SRL with b=32 (s=0) -> result=a, carry=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid rises -> result and flags stable, in_ready=0, a second in_valid is not accepted. On out_ready, the block returns to IDLE and accepts the next op one cycle later.
- Reset mid-MUL: assert rst_n=0 at cycle 10 of a MUL -> all outputs reset immediately. After release, no stale out_valid appears, and a new ADD 2+2 -> result 4 with latency 1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU: opcodes, FSM states and the result flag set.
package alu_pkg;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_MUL = 3'b100,
      ALU_SLL = 3'b101,
      ALU_SRL = 3'b110,
      ALU_SRA = 3'b111
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MUL,
      ST_DONE
   } alu_state_e;

   typedef struct packed {
      logic carry;
      logic zero;
      logic negative;
      logic overflow;
   } alu_flags_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier: one multiplier bit per cycle, WIDTH cycles total.
module alu_mul_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] prod_lo,
   output logic [WIDTH-1:0] prod_hi
);

   localparam int CW = $clog2(WIDTH);

   logic [WIDTH-1:0] mcand_reg;
   logic [WIDTH-1:0] hi_reg;
   logic [WIDTH-1:0] lo_reg;
   logic [CW-1:0]    count_reg;
   logic             busy_reg;

   logic [WIDTH-1:0] src_mc;
   logic [WIDTH-1:0] src_hi;
   logic [WIDTH-1:0] src_lo;
   logic [WIDTH:0]   step_sum;
   logic             advance;

   // The start edge already performs the first step straight from the operand inputs,
   // so the last step lands one cycle before done is seen by the caller.
   always_comb begin
      src_mc   = start ? a : mcand_reg;
      src_hi   = start ? '0 : hi_reg;
      src_lo   = start ? b : lo_reg;
      step_sum = {1'b0, src_hi} + (src_lo[0] ? {1'b0, src_mc} : '0);
      advance  = start || (busy_reg && (count_reg != '0));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand_reg <= '0;
         hi_reg    <= '0;
         lo_reg    <= '0;
         count_reg <= '0;
         busy_reg  <= 1'b0;
      end else begin
         if (advance) begin
            hi_reg <= step_sum[WIDTH:1];
            lo_reg <= {step_sum[0], src_lo[WIDTH-1:1]};
         end
         if (start) begin
            mcand_reg <= a;
            count_reg <= CW'(WIDTH - 1);
            busy_reg  <= 1'b1;
         end else if (busy_reg) begin
            if (count_reg != '0) begin
               count_reg <= count_reg - 1'b1;
            end else begin
               busy_reg <= 1'b0;
            end
         end
      end
   end

   assign busy    = busy_reg;
   assign done    = busy_reg && (count_reg == '0);
   assign prod_lo = lo_reg;
   assign prod_hi = hi_reg;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes, registered result and flags, optional iterative multiply.
module alu_mc
   import alu_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter bit MUL_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       opcode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             zero,
   output logic             negative,
   output logic             overflow
);

   localparam int SW = $clog2(WIDTH);

   alu_state_e       state_reg, state_next;
   logic             run_reg;
   logic [WIDTH-1:0] result_reg;
   alu_flags_t       flags_reg;

   alu_op_e          op;
   logic             accept;
   logic             load;
   logic             mul_start;
   logic             mul_busy;
   logic             mul_done;
   logic [WIDTH-1:0] prod_lo;
   logic [WIDTH-1:0] prod_hi;

   logic [SW-1:0]    shamt;
   logic [WIDTH:0]   add_ext, sub_ext, sll_ext, srl_ext, sra_ext;
   logic [WIDTH-1:0] sc_res;
   logic             sc_carry, sc_ovf;
   logic [WIDTH-1:0] res_next;
   alu_flags_t       flags_next;

   assign op     = alu_op_e'(opcode);
   assign shamt  = b[SW-1:0];
   assign accept = in_valid && in_ready;

   // Shifts run on a one-bit-extended operand so the extra bit is the last bit shifted out.
   always_comb begin
      add_ext = {1'b0, a} + {1'b0, b};
      sub_ext = {1'b0, a} - {1'b0, b};
      sll_ext = {1'b0, a} << shamt;
      srl_ext = {a, 1'b0} >> shamt;
      sra_ext = $unsigned($signed({a, 1'b0}) >>> shamt);
   end

   always_comb begin
      sc_res   = '0;
      sc_carry = 1'b0;
      sc_ovf   = 1'b0;
      case (op)
         ALU_ADD: begin
            sc_res   = add_ext[WIDTH-1:0];
            sc_carry = add_ext[WIDTH];
            sc_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sc_res[WIDTH-1] != a[WIDTH-1]);
         end
         ALU_SUB: begin
            sc_res   = sub_ext[WIDTH-1:0];
            sc_carry = sub_ext[WIDTH];
            sc_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (sc_res[WIDTH-1] != a[WIDTH-1]);
         end
         ALU_AND: sc_res = a & b;
         ALU_OR:  sc_res = a | b;
         ALU_MUL: sc_res = '0;
         ALU_SLL: begin
            sc_res   = sll_ext[WIDTH-1:0];
            sc_carry = sll_ext[WIDTH];
         end
         ALU_SRL: begin
            sc_res   = srl_ext[WIDTH:1];
            sc_carry = srl_ext[0];
         end
         ALU_SRA: begin
            sc_res   = sra_ext[WIDTH:1];
            sc_carry = sra_ext[0];
         end
      endcase
   end

   always_comb begin
      if (state_reg == ST_MUL) begin
         res_next            = prod_lo;
         flags_next.carry    = |prod_hi;
         flags_next.overflow = |prod_hi;
      end else begin
         res_next            = sc_res;
         flags_next.carry    = sc_carry;
         flags_next.overflow = sc_ovf;
      end
      flags_next.zero     = (res_next == '0);
      flags_next.negative = res_next[WIDTH-1];
   end

   always_comb begin
      state_next = state_reg;
      mul_start  = 1'b0;
      load       = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (accept) begin
               if ((op == ALU_MUL) && MUL_EN) begin
                  mul_start  = 1'b1;
                  state_next = ST_MUL;
               end else begin
                  load       = 1'b1;
                  state_next = ST_DONE;
               end
            end
         end
         ST_MUL: begin
            if (mul_done) begin
               load       = 1'b1;
               state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // run_reg keeps in_ready low until the first clock after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= ST_IDLE;
         run_reg    <= 1'b0;
         result_reg <= '0;
         flags_reg  <= '0;
      end else begin
         state_reg <= state_next;
         run_reg   <= 1'b1;
         if (load) begin
            result_reg <= res_next;
            flags_reg  <= flags_next;
         end
      end
   end

   generate
      if (MUL_EN) begin : g_mul
         alu_mul_iter #(
            .WIDTH (WIDTH)
         ) u_mul (
            .clk     (clk),
            .rst_n   (rst_n),
            .start   (mul_start),
            .a       (a),
            .b       (b),
            .busy    (mul_busy),
            .done    (mul_done),
            .prod_lo (prod_lo),
            .prod_hi (prod_hi)
         );
      end else begin : g_no_mul
         assign mul_busy = 1'b0;
         assign mul_done = 1'b0;
         assign prod_lo  = '0;
         assign prod_hi  = '0;
      end
   endgenerate

   assign in_ready  = (state_reg == ST_IDLE) && run_reg && !mul_busy;
   assign out_valid = (state_reg == ST_DONE);
   assign result    = result_reg;
   assign carry     = flags_reg.carry;
   assign zero      = flags_reg.zero;
   assign negative  = flags_reg.negative;
   assign overflow  = flags_reg.overflow;

endmodule
